// File: rtl/btn_counter_multi.sv
// Multi-channel up/down button counter: each button is synchronised, debounced
// and edge-detected with optional hold-to-repeat, and feeds a bounded per-channel count.

module btn_press #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic step
);
    // state  | meaning
    // IDLE   | debounced level low, waiting for a press
    // HELD   | press accepted, hold timer running toward auto-repeat
    // REPEAT | auto-repeat active, one step per repeat period

    localparam int DB_W   = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);
    localparam int RPT_W  = (REPEAT_CYCLES < 2) ? 1 : $clog2(REPEAT_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(REPEAT_CYCLES - 1);
    localparam bit                HOLD_EN   = (HOLD_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic              sync1, sync2, lvl;
    logic [DB_W-1:0]   db_cnt;
    state_t            state, state_d;
    logic [HOLD_W-1:0] hold_cnt, hold_d;
    logic [RPT_W-1:0]  rpt_cnt, rpt_d;
    logic              step_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            lvl    <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == lvl) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                lvl    <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            rpt_cnt  <= '0;
            step     <= 1'b0;
        end else begin
            state    <= state_d;
            hold_cnt <= hold_d;
            rpt_cnt  <= rpt_d;
            step     <= step_d;
        end
    end

    // step is registered, so a count update lands one cycle after the FSM sees lvl
    always_comb begin
        state_d = state;
        hold_d  = hold_cnt;
        rpt_d   = rpt_cnt;
        step_d  = 1'b0;
        unique case (state)
            IDLE: begin
                hold_d = '0;
                rpt_d  = '0;
                if (lvl) begin
                    state_d = HELD;
                    step_d  = 1'b1;
                end
            end
            HELD: begin
                if (!lvl) begin
                    state_d = IDLE;
                    hold_d  = '0;
                    rpt_d   = '0;
                end else if (HOLD_EN) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_d = REPEAT;
                        step_d  = 1'b1;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_cnt + 1'b1;
                    end
                end
            end
            REPEAT: begin
                if (!lvl) begin
                    state_d = IDLE;
                    hold_d  = '0;
                    rpt_d   = '0;
                end else if (rpt_cnt == RPT_LAST) begin
                    step_d = 1'b1;
                    rpt_d  = '0;
                end else begin
                    rpt_d = rpt_cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
                rpt_d   = '0;
            end
        endcase
    end
endmodule

module btn_counter_multi #(
    parameter int NUM_CH          = 2,
    parameter int CNT_W           = 4,
    parameter int MAX_VAL         = 15,
    parameter int WRAP            = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       btn_up,
    input  logic [NUM_CH-1:0]       btn_dn,
    input  logic [NUM_CH-1:0]       clr,
    output logic [NUM_CH*CNT_W-1:0] cnt,
    output logic [NUM_CH-1:0]       changed
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VAL);
    localparam bit               WRAP_EN = (WRAP != 0);

    if (NUM_CH < 1 || CNT_W < 1 || MAX_VAL < 1 || MAX_VAL > (2**CNT_W) - 1 ||
        DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1 || HOLD_CYCLES < 0) begin : g_bad_param
        $error("btn_counter_multi: illegal parameter set");
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic             up_step, dn_step;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             chg_q;

        btn_press #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_up (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn_up[ch]),
            .step (up_step)
        );

        btn_press #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_dn (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn_dn[ch]),
            .step (dn_step)
        );

        // clear wins over steps; opposing steps cancel; bounds compare against MAX_VAL
        always_comb begin
            cnt_d = cnt_q;
            if (clr[ch]) begin
                cnt_d = '0;
            end else if (up_step && !dn_step) begin
                if (cnt_q == MAX_CNT) cnt_d = WRAP_EN ? '0 : cnt_q;
                else                  cnt_d = cnt_q + 1'b1;
            end else if (dn_step && !up_step) begin
                if (cnt_q == '0) cnt_d = WRAP_EN ? MAX_CNT : cnt_q;
                else             cnt_d = cnt_q - 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                chg_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                chg_q <= (cnt_d != cnt_q);
            end
        end

        assign cnt[ch*CNT_W +: CNT_W] = cnt_q;
        assign changed[ch]            = chg_q;
    end
endmodule

// File: tb/tb_btn_counter_multi.sv
// Bench for btn_counter_multi: a wrapping and a saturating instance share stimulus
// and are compared each cycle against a behavioural model of the button rules.

module tb_btn_counter_multi;
    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 3;
    localparam int MAX_VAL = 5;
    localparam int DB      = 4;
    localparam int HOLD    = 20;
    localparam int RPT     = 5;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_CH-1:0]       btn_up = '0;
    logic [NUM_CH-1:0]       btn_dn = '0;
    logic [NUM_CH-1:0]       clr = '0;
    logic [NUM_CH*CNT_W-1:0] cnt_w, cnt_s;
    logic [NUM_CH-1:0]       chg_w, chg_s;

    always #5 clk = ~clk;

    btn_counter_multi #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .MAX_VAL(MAX_VAL), .WRAP(1),
        .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT)
    ) u_wrap (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_dn(btn_dn),
        .clr(clr), .cnt(cnt_w), .changed(chg_w)
    );

    btn_counter_multi #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .MAX_VAL(MAX_VAL), .WRAP(0),
        .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_dn(btn_dn),
        .clr(clr), .cnt(cnt_s), .changed(chg_s)
    );

    int checks = 0;
    int errors = 0;

    // button model indexed [channel][0=up,1=down]; counts indexed [0=wrap,1=sat][channel]
    int s1[2][2], s2[2][2], lvl[2][2], run_len[2][2], age[2][2], pend[2][2];
    int m_cnt[2][2], m_chg[2][2];
    int pulses[2][2];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int apply(input int c, input int up, input int dn, input int cl, input int wrap);
        if (cl != 0) return 0;
        if (up == dn) return c;
        if (up != 0) return wrap ? (c + 1) % (MAX_VAL + 1) : ((c < MAX_VAL) ? c + 1 : MAX_VAL);
        return wrap ? (c + MAX_VAL) % (MAX_VAL + 1) : ((c > 0) ? c - 1 : 0);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int d = 0; d < 2; d++) begin
                s1[c][d] = 0; s2[c][d] = 0; lvl[c][d] = 0;
                run_len[c][d] = 0; age[c][d] = 0; pend[c][d] = 0;
                m_cnt[d][c] = 0; m_chg[d][c] = 0;
            end
        end
    endtask

    // one rising edge of the model; each stage reads its upstream value from before the edge
    task automatic model_edge();
        int nc, raw, stp;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 2; i++) begin
                nc = apply(m_cnt[i][c], pend[c][0], pend[c][1], int'(clr[c]), (i == 0) ? 1 : 0);
                m_chg[i][c] = (nc != m_cnt[i][c]) ? 1 : 0;
                m_cnt[i][c] = nc;
            end
            for (int d = 0; d < 2; d++) begin
                raw = (d == 0) ? int'(btn_up[c]) : int'(btn_dn[c]);
                stp = 0;
                if (lvl[c][d] != 0) begin
                    if (age[c][d] == 0) stp = 1;
                    else if (HOLD != 0 && age[c][d] >= HOLD && (age[c][d] - HOLD) % RPT == 0) stp = 1;
                    age[c][d]++;
                end else begin
                    age[c][d] = 0;
                end
                pend[c][d] = stp;
                if (s2[c][d] != lvl[c][d]) begin
                    run_len[c][d]++;
                    if (run_len[c][d] == DB) begin
                        lvl[c][d] = s2[c][d];
                        run_len[c][d] = 0;
                    end
                end else begin
                    run_len[c][d] = 0;
                end
                s2[c][d] = s1[c][d];
                s1[c][d] = raw;
            end
        end
    endtask

    task automatic compare();
        check("cnt_wrap", int'(cnt_w), m_cnt[0][0] + 8 * m_cnt[0][1]);
        check("chg_wrap", int'(chg_w), m_chg[0][0] + 2 * m_chg[0][1]);
        check("cnt_sat",  int'(cnt_s), m_cnt[1][0] + 8 * m_cnt[1][1]);
        check("chg_sat",  int'(chg_s), m_chg[1][0] + 2 * m_chg[1][1]);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        @(negedge clk);
        compare();
        for (int c = 0; c < 2; c++) begin
            if (chg_w[c]) pulses[0][c]++;
            if (chg_s[c]) pulses[1][c]++;
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic clear_pulses();
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 2; c++) pulses[i][c] = 0;
    endtask

    task automatic press(input int c, input int d, input int hi, input int lo);
        if (d == 0) btn_up[c] = 1'b1; else btn_dn[c] = 1'b1;
        run(hi);
        if (d == 0) btn_up[c] = 1'b0; else btn_dn[c] = 1'b0;
        run(lo);
    endtask

    task automatic pulse_clr0();
        clr[0] = 1'b1;
        run(1);
        clr[0] = 1'b0;
        run(1);
    endtask

    initial begin
        model_reset();
        clear_pulses();
        run(3);
        check("rst_cnt_wrap", int'(cnt_w), 0);
        check("rst_chg_sat", int'(chg_s), 0);
        rst_n = 1'b1;
        run(2);

        // latency: first sampled at edge t, count appears at edge t+7
        btn_up[0] = 1'b1;
        run(7);
        check("lat_early", int'(cnt_w[2:0]), 0);
        run(1);
        check("lat_cnt", int'(cnt_w[2:0]), 1);
        check("lat_chg", int'(chg_w[0]), 1);
        run(2);
        btn_up[0] = 1'b0;
        run(12);
        check("lat_bus", int'(cnt_w), 1);
        check("lat_pulses", pulses[0][0], 1);

        // bounce shorter than the debounce window
        clear_pulses();
        repeat (5) begin
            btn_up[1] = 1'b1; run(3);
            btn_up[1] = 1'b0; run(2);
        end
        run(10);
        check("bounce_cnt", int'(cnt_w[5:3]), 0);
        check("bounce_pulses", pulses[0][1] + pulses[1][1], 0);

        // wrap versus saturate
        pulse_clr0();
        repeat (6) press(0, 0, 8, 10);
        check("six_up_wrap", int'(cnt_w[2:0]), 0);
        check("six_up_sat", int'(cnt_s[2:0]), 5);
        clear_pulses();
        press(0, 0, 8, 10);
        check("seventh_sat", int'(cnt_s[2:0]), 5);
        check("seventh_sat_chg", pulses[1][0], 0);
        check("seventh_wrap", int'(cnt_w[2:0]), 1);
        pulse_clr0();
        clear_pulses();
        press(0, 1, 8, 10);
        check("dn_at0_wrap", int'(cnt_w[2:0]), 5);
        check("dn_at0_sat", int'(cnt_s[2:0]), 0);
        check("dn_at0_sat_chg", pulses[1][0], 0);

        // auto-repeat from 5: steps at press, +20, then every 5 while held
        pulse_clr0();
        repeat (5) press(0, 0, 8, 10);
        check("pre_rpt_sat", int'(cnt_s[2:0]), 5);
        clear_pulses();
        btn_dn[0] = 1'b1;
        run(60);
        btn_dn[0] = 1'b0;
        run(12);
        check("rpt_sat", int'(cnt_s[2:0]), 0);
        check("rpt_wrap", int'(cnt_w[2:0]), 2);
        check("rpt_sat_steps", pulses[1][0], 5);
        check("rpt_wrap_steps", pulses[0][0], 9);
        clear_pulses();
        run(30);
        check("post_release", pulses[0][0] + pulses[1][0], 0);

        // up and down accepted together cancel
        btn_up[0] = 1'b1; btn_dn[0] = 1'b1;
        run(10);
        btn_up[0] = 1'b0; btn_dn[0] = 1'b0;
        run(12);
        check("cancel_wrap", int'(cnt_w[2:0]), 2);
        check("cancel_pulses", pulses[0][0] + pulses[1][0], 0);

        // clear in the same cycle as an up step
        btn_up[0] = 1'b1;
        run(7);
        clr[0] = 1'b1;
        run(1);
        clr[0] = 1'b0;
        run(3);
        btn_up[0] = 1'b0;
        run(12);
        check("clr_step_wrap", int'(cnt_w[2:0]), 0);
        check("clr_step_sat", int'(cnt_s[2:0]), 0);

        // both channels step together
        btn_up = 2'b11;
        run(10);
        btn_up = 2'b00;
        run(12);
        check("both_wrap", int'(cnt_w), 9);
        check("both_sat", int'(cnt_s), 9);

        // reset during repeat
        btn_up[0] = 1'b1;
        run(28);
        check("pre_rst_cnt", int'(cnt_w[2:0]), 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cnt", int'(cnt_w) + int'(cnt_s), 0);
        check("async_rst_chg", int'(chg_w) + int'(chg_s), 0);
        model_reset();
        run(2);
        rst_n = 1'b1;
        run(7);
        check("post_rst_early", int'(cnt_w[2:0]), 0);
        run(1);
        check("post_rst_cnt", int'(cnt_w[2:0]), 1);
        check("post_rst_sat", int'(cnt_s), 1);
        btn_up[0] = 1'b0;
        run(12);

        // random buttons and clears
        repeat (800) begin
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(0, 15) == 0) btn_up[c] = ~btn_up[c];
                if ($urandom_range(0, 15) == 0) btn_dn[c] = ~btn_dn[c];
                clr[c] = ($urandom_range(0, 59) == 0);
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
